// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor and parity helpers.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } uart_state_e;

  // Rounded clocks-per-bit; shared with the receiver so both ends agree.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + (baud / 32'd2)) / baud;
  endfunction

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the SOC core (master) and the UART transmitter (slave).
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the transmitter; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o   = (wr_q == rd_q);
  assign level_o   = wr_q - rd_q;
  assign dout_o    = mem_q[rd_q[AW-1:0]];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_q <= wr_q + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: 8N1 frames on txd from a small FIFO.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  uart_tx_if.slave                      bus,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    shift_q;
  logic [2:0]    idx_q;
  logic          txd_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic          push_s;
  logic          pop_s;
  logic          cnt_last_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_s),
    .din_i   (bus.tx_data),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level)
  );

  assign bus.tx_ready = !fifo_full_s;
  assign push_s       = bus.tx_valid && !fifo_full_s;
  assign cnt_last_s   = (cnt_q == '0);
  assign txd          = txd_q;
  assign busy         = (state_q != S_IDLE) || !fifo_empty_s;

  // Pop in IDLE, or on the last STOP cycle so frames run back to back.
  always_comb begin
    pop_s = 1'b0;
    if (state_q == S_IDLE) begin
      pop_s = !fifo_empty_s;
    end else if (state_q == S_STOP) begin
      pop_s = cnt_last_s && !fifo_empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= 8'h00;
      idx_q   <= 3'd0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (!fifo_empty_s) begin
            state_q <= S_START;
            cnt_q   <= CNT_MAX;
            shift_q <= fifo_dout_s;
            txd_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= even_parity(fifo_dout_s);
`endif
          end
        end
        S_START: begin
          if (cnt_last_s) begin
            state_q <= S_DATA;
            cnt_q   <= CNT_MAX;
            idx_q   <= 3'd0;
            txd_q   <= shift_q[0];
          end else begin
            cnt_q   <= cnt_q - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_last_s) begin
            cnt_q <= CNT_MAX;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              txd_q   <= par_q;
`else
              state_q <= S_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              // Next bit is shift_q[1]: drive it while shifting so txd stays registered.
              shift_q <= {1'b0, shift_q[7:1]};
              idx_q   <= idx_q + 3'd1;
              txd_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (cnt_last_s) begin
            state_q <= S_STOP;
            cnt_q   <= CNT_MAX;
            txd_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt_last_s) begin
            if (!fifo_empty_s) begin
              state_q <= S_START;
              cnt_q   <= CNT_MAX;
              shift_q <= fifo_dout_s;
              txd_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par_q   <= even_parity(fifo_dout_s);
`endif
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table of single frames plus
// hand-written back-to-back, full-FIFO and mid-frame reset sequences.
module tb_uart_tx;

  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DIV;

  logic       clk = 1'b0;
  logic       resetn;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_level;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD_RATE   (100_000),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frame_ok;
    int         start_cyc;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  frame_t     dec_q[$];
  logic [7:0] sb_q[$];
  int         cyc;
  int         checks;
  int         errors;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line decoder: samples mid-bit relative to the detected start edge.
  initial begin
    frame_t rec;
    bit     active;
    int     cnt;
    int     bitn;
    active = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (txd === 1'b0) begin
          active = 1'b1;
          cnt = 0;
          rec.data = 8'h00;
          rec.par = 1'b0;
          rec.frame_ok = 1'b1;
          rec.start_cyc = cyc;
        end
      end else begin
        cnt++;
        if ((cnt % DIV) == DIV / 2) begin
          bitn = cnt / DIV;
          if (bitn == 0) begin
            if (txd !== 1'b0) rec.frame_ok = 1'b0;
          end else if (bitn <= 8) begin
            rec.data[bitn-1] = txd;
          end else if (bitn == NB - 1) begin
            if (txd !== 1'b1) rec.frame_ok = 1'b0;
          end else begin
            rec.par = txd;
          end
        end
        if (cnt == FL - 1) begin
          dec_q.push_back(rec);
          active = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Holds tx_valid until the byte is taken; call 1 time unit after a posedge.
  task automatic push_byte(input logic [7:0] b);
    bit   acc;
    logic rdy;
    acc = 1'b0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      rdy = bus.tx_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    check("push_accept", acc, 1'b1);
    if (acc) sb_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int t = 0; t < budget && dec_q.size() < n; t++) @(negedge clk);
    check("frames_seen", dec_q.size(), n);
  endtask

  task automatic check_frame(input string tag, output int start);
    frame_t     f;
    logic [7:0] exp;
    bit         avail;
    start = -1;
    avail = (dec_q.size() > 0) && (sb_q.size() > 0);
    check({tag, "_avail"}, avail, 1'b1);
    if (avail) begin
      f = dec_q.pop_front();
      exp = sb_q.pop_front();
      start = f.start_cyc;
      check({tag, "_data"}, f.data, exp);
      check({tag, "_framing"}, f.frame_ok, 1'b1);
`ifdef UART_TX_PARITY_EN
      check({tag, "_parity"}, f.par, ^exp);
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    logic [10:0] fb;
    int          pc;
    int          mism;
    int          s0, s1, s2, sx;
    int          bad;
    int          waited;
    logic        rdy;
    logic        busy_last;

    checks = 0;
    errors = 0;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0};
    vecs[2] = '{8'h07, 1'b1};
    vecs[3] = '{8'h03, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h01, 1'b1};

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_ready", bus.tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    resetn = 1'b1;

    mism = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) mism++;
    end
    check("idle_txd_high", mism, 0);
    @(posedge clk);
    #1;

    // Single frames, cycle-exact waveform against the table.
    for (int i = 0; i < 6; i++) begin
      fb = 11'h7FF;
      fb[0] = 1'b0;
      fb[8:1] = vecs[i].data;
`ifdef UART_TX_PARITY_EN
      fb[9] = vecs[i].exp_par;
`endif
      push_byte(vecs[i].data);
      pc = cyc;
      bus.tx_valid = 1'b0;
      @(posedge clk);
      mism = 0;
      busy_last = 1'b0;
      for (int c = 0; c < FL; c++) begin
        @(negedge clk);
        if (txd !== fb[c / DIV]) mism++;
        busy_last = busy;
      end
      check($sformatf("wave_%02h", vecs[i].data), mism, 0);
      check("busy_last_cycle", busy_last, 1'b1);
      @(negedge clk);
      check("busy_fall", busy, 1'b0);
      wait_frames(1, 50);
      check_frame($sformatf("single_%02h", vecs[i].data), sx);
      check("start_latency", sx, pc + 1);
      @(posedge clk);
      #1;
    end

    // Back-to-back: three frames with no idle gap.
    push_byte(8'h00);
    pc = cyc;
    push_byte(8'hFF);
    push_byte(8'h55);
    bus.tx_valid = 1'b0;
    wait_frames(3, 3 * FL + 100);
    check_frame("b2b0", s0);
    check_frame("b2b1", s1);
    check_frame("b2b2", s2);
    check("b2b_latency", s0, pc + 1);
    check("b2b_gap1", s1 - s0, FL);
    check("b2b_gap2", s2 - s1, FL);
    repeat (4) @(negedge clk);
    check("b2b_idle_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    // Full FIFO: five pushes fill it, the sixth stalls until a pop frees a slot.
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    push_byte(8'h78);
    push_byte(8'h9A);
    check("full_ready_low", bus.tx_ready, 1'b0);
    check("full_level", fifo_level, 3'd4);
    bus.tx_data  = 8'hBC;
    bus.tx_valid = 1'b1;
    bad = 0;
    waited = 0;
    rdy = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      rdy = bus.tx_ready;
      if (rdy !== 1'b1 && fifo_level !== 3'd4) bad++;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) break;
      waited++;
    end
    bus.tx_valid = 1'b0;
    check("sixth_accepted", rdy, 1'b1);
    if (rdy === 1'b1) sb_q.push_back(8'hBC);
    check("stall_level_4", bad, 0);
    check("stall_long", (waited > 100), 1'b1);
    wait_frames(6, 6 * FL + 200);
    for (int k = 0; k < 6; k++) check_frame($sformatf("full%0d", k), sx);
    repeat (2 * FL) @(negedge clk);
    check("full_no_extra", dec_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset during data bit 3 of 0x3C with two bytes still queued.
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    bus.tx_valid = 1'b0;
    mism = 1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        mism = 0;
        break;
      end
    end
    check("rst_frame_started", mism, 0);
    repeat (4 * DIV + 6) @(negedge clk);
    check("rst_pre_level", fifo_level, 3'd2);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_ready", bus.tx_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    resetn = 1'b1;
    sb_q.delete();
    dec_q.delete();
    mism = 0;
    repeat (3 * FL) begin
      @(negedge clk);
      if (txd !== 1'b1) mism++;
    end
    check("midrst_quiet", mism, 0);
    check("midrst_no_frames", dec_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
